// File: rtl/fetch_stall_unit.sv
// fetch_stall_unit: owns the PC and the IF/ID latch. It responds to hazard-unit
// hold/bubble requests and to taken branches. It assembles two-word (opcode +
// immediate) instructions from a 16-bit instruction memory.
// Optional feature macro: FETCH_STALL_COUNTER_EN enables the saturating stall-cycle
// counter. When the macro is undefined, Stall_Count is tied to zero.
module fetch_stall_unit #(
  parameter int                  PC_WIDTH        = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = '0,
  parameter logic [15:0]         NOP_WORD        = 16'h0,
  parameter int                  IMM_BIT         = 15,
  parameter int                  STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Keep_PC,
  input  logic                       Keep_Fetched_Instruction,
  input  logic                       Flush_MUX_Selector,
  input  logic                       Branch_Taken,
  input  logic [PC_WIDTH-1:0]        Branch_Target,
  input  logic [15:0]                Imem_Data,
  output logic [PC_WIDTH-1:0]        Imem_Addr,
  output logic [15:0]                IF_ID_Instr,
  output logic [15:0]                IF_ID_Imm,
  output logic [PC_WIDTH-1:0]        IF_ID_PC,
  output logic                       IF_ID_Valid,
  output logic [15:0]                Dec_Instr,
  output logic [STALL_CNT_WIDTH-1:0] Stall_Count
);

  typedef enum logic {S_OP = 1'b0, S_IMM = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [PC_WIDTH-1:0]  r_pc;
  logic [15:0]          r_instr;
  logic [15:0]          r_imm;
  logic [PC_WIDTH-1:0]  r_ifpc;
  logic                 r_valid;
  logic [15:0]          r_op_hold;
  logic [PC_WIDTH-1:0]  r_op_pc;

  logic [PC_WIDTH-1:0]  w_pc_nxt;
  logic [15:0]          w_instr_nxt;
  logic [15:0]          w_imm_nxt;
  logic [PC_WIDTH-1:0]  w_ifpc_nxt;
  logic                 w_valid_nxt;
  logic [15:0]          w_op_hold_nxt;
  logic [PC_WIDTH-1:0]  w_op_pc_nxt;

  logic                 w_stall;
  logic                 w_is_imm;

  // Any hold request freezes the PC and the FSM. Keep_Fetched alone also counts as a full hold.
  assign w_stall  = Keep_PC | Keep_Fetched_Instruction;
  assign w_is_imm = Imem_Data[IMM_BIT];

  // State register: tracks whether the opcode half of a two-word instruction is pending
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_OP;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: a branch always restarts at an opcode, and a stall freezes the state
  always_comb begin
    w_state_nxt = r_state;
    if (Branch_Taken) begin
      w_state_nxt = S_OP;
    end else if (!w_stall) begin
      case (r_state)
        S_OP:    w_state_nxt = w_is_imm ? S_IMM : S_OP;
        S_IMM:   w_state_nxt = S_OP;
        default: w_state_nxt = S_OP;
      endcase
    end
  end

  // Output/datapath logic: next PC, IF/ID contents and opcode-hold registers
  always_comb begin
    w_pc_nxt      = r_pc;
    w_instr_nxt   = r_instr;
    w_imm_nxt     = r_imm;
    w_ifpc_nxt    = r_ifpc;
    w_valid_nxt   = r_valid;
    w_op_hold_nxt = r_op_hold;
    w_op_pc_nxt   = r_op_pc;
    if (Branch_Taken) begin
      // Redirect: any half-fetched opcode is simply forgotten because the FSM returns to S_OP
      w_pc_nxt    = Branch_Target;
      w_instr_nxt = NOP_WORD;
      w_imm_nxt   = 16'h0;
      w_ifpc_nxt  = '0;
      w_valid_nxt = 1'b0;
    end else if (Keep_Fetched_Instruction) begin
      // Full hold: nothing moves
      w_pc_nxt = r_pc;
    end else if (Keep_PC) begin
      // Bubble into decode while fetch is frozen
      w_instr_nxt = NOP_WORD;
      w_imm_nxt   = 16'h0;
      w_ifpc_nxt  = '0;
      w_valid_nxt = 1'b0;
    end else begin
      w_pc_nxt = r_pc + PC_WIDTH'(1);
      case (r_state)
        S_OP: begin
          if (w_is_imm) begin
            w_op_hold_nxt = Imem_Data;
            w_op_pc_nxt   = r_pc;
            w_instr_nxt   = NOP_WORD;
            w_imm_nxt     = 16'h0;
            w_ifpc_nxt    = '0;
            w_valid_nxt   = 1'b0;
          end else begin
            w_instr_nxt = Imem_Data;
            w_imm_nxt   = 16'h0;
            w_ifpc_nxt  = r_pc;
            w_valid_nxt = 1'b1;
          end
        end
        S_IMM: begin
          w_instr_nxt = r_op_hold;
          w_imm_nxt   = Imem_Data;
          w_ifpc_nxt  = r_op_pc;
          w_valid_nxt = 1'b1;
        end
        default: begin
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // PC and IF/ID latch: these have architecturally defined reset values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= NOP_WORD;
      r_imm   <= 16'h0;
      r_ifpc  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_imm   <= w_imm_nxt;
      r_ifpc  <= w_ifpc_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Opcode-hold registers: only read while in S_IMM, so no reset is needed
  always_ff @(posedge clk) begin
    r_op_hold <= w_op_hold_nxt;
    r_op_pc   <= w_op_pc_nxt;
  end

`ifdef FETCH_STALL_COUNTER_EN
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  // Stall-cycle counter: counts Keep_PC cycles that are not overridden by a branch, and saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (Keep_PC && !Branch_Taken && (r_stall_cnt != {STALL_CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_WIDTH'(1);
    end
  end

  assign Stall_Count = r_stall_cnt;
`else
  assign Stall_Count = '0;
`endif

  assign Imem_Addr   = r_pc;
  assign IF_ID_Instr = r_instr;
  assign IF_ID_Imm   = r_imm;
  assign IF_ID_PC    = r_ifpc;
  assign IF_ID_Valid = r_valid;
  assign Dec_Instr   = Flush_MUX_Selector ? NOP_WORD : r_instr;

endmodule

// File: tb/tb_fetch_stall_unit.sv
// Testbench for fetch_stall_unit. A transaction-level model tracks the fetch position,
// any pending opcode, and the contents of the decode latch. The model is compared
// against the DUT on every cycle. Directed literal checks pin down the model itself.
module tb_fetch_stall_unit;

`ifdef FETCH_STALL_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        Keep_PC, Keep_Fetched_Instruction, Flush_MUX_Selector, Branch_Taken;
  logic [31:0] Branch_Target;
  logic [15:0] Imem_Data;
  logic [31:0] Imem_Addr;
  logic [15:0] IF_ID_Instr, IF_ID_Imm, Dec_Instr, Stall_Count;
  logic [31:0] IF_ID_PC;
  logic        IF_ID_Valid;

  logic [15:0] mem [0:255];
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign Imem_Data = mem[Imem_Addr[7:0]];

  fetch_stall_unit dut (
    .clk(clk), .rst(rst),
    .Keep_PC(Keep_PC), .Keep_Fetched_Instruction(Keep_Fetched_Instruction),
    .Flush_MUX_Selector(Flush_MUX_Selector),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Imem_Data(Imem_Data), .Imem_Addr(Imem_Addr),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_Imm(IF_ID_Imm), .IF_ID_PC(IF_ID_PC),
    .IF_ID_Valid(IF_ID_Valid), .Dec_Instr(Dec_Instr), .Stall_Count(Stall_Count)
  );

  // Reference model state: fetch address, a pending opcode (if any), and what decode sees
  typedef struct packed {
    logic [31:0] pc;
    logic        pend;
    logic [15:0] op;
    logic [31:0] oppc;
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] ifpc;
    logic        valid;
    logic [15:0] cnt;
  } mstate_t;

  mstate_t m;
  bit      model_ok = 1'b0;

  function automatic mstate_t step_model(mstate_t s, logic r, logic bt, logic [31:0] tgt,
                                         logic kp, logic kf, logic [15:0] w);
    mstate_t n = s;
    if (r) begin
      n = '0;
      return n;
    end
    if (CNT_EN && kp && !bt && s.cnt != 16'hFFFF) n.cnt = s.cnt + 16'd1;
    if (bt) begin
      n.pc = tgt; n.pend = 1'b0; n.instr = 16'h0; n.imm = 16'h0; n.valid = 1'b0;
    end else if (kf) begin
      // everything frozen
    end else if (kp) begin
      n.instr = 16'h0; n.imm = 16'h0; n.valid = 1'b0;
    end else begin
      n.pc = s.pc + 32'd1;
      if (s.pend) begin
        n.instr = s.op; n.imm = w; n.ifpc = s.oppc; n.valid = 1'b1; n.pend = 1'b0;
      end else if (w[15]) begin
        n.op = w; n.oppc = s.pc; n.pend = 1'b1;
        n.instr = 16'h0; n.imm = 16'h0; n.valid = 1'b0;
      end else begin
        n.instr = w; n.imm = 16'h0; n.ifpc = s.pc; n.valid = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= step_model(m, rst, Branch_Taken, Branch_Target, Keep_PC,
                    Keep_Fetched_Instruction, mem[m.pc[7:0]]);
    if (rst) model_ok <= 1'b1;
  end

  // Compare process: every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (model_ok) begin
      logic [15:0] exp_dec;
      exp_dec = Flush_MUX_Selector ? 16'h0 : m.instr;
      vectors++;
      if (Imem_Addr !== m.pc || IF_ID_Instr !== m.instr || IF_ID_Imm !== m.imm ||
          IF_ID_Valid !== m.valid || (m.valid && IF_ID_PC !== m.ifpc) ||
          Dec_Instr !== exp_dec || Stall_Count !== m.cnt) begin
        errors++;
        $display("FAIL model t=%0t got addr=%h instr=%h imm=%h pc=%h v=%b dec=%h cnt=%h exp addr=%h instr=%h imm=%h pc=%h v=%b dec=%h cnt=%h",
                 $time, Imem_Addr, IF_ID_Instr, IF_ID_Imm, IF_ID_PC, IF_ID_Valid, Dec_Instr,
                 Stall_Count, m.pc, m.instr, m.imm, m.ifpc, m.valid, exp_dec, m.cnt);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic kp, input logic kf, input logic fl, input logic bt,
                       input logic [31:0] tgt);
    Keep_PC = kp; Keep_Fetched_Instruction = kf; Flush_MUX_Selector = fl;
    Branch_Taken = bt; Branch_Target = tgt;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
    mem[0] = 16'h1234; mem[1] = 16'h8001; mem[2] = 16'hBEEF;
    mem[3] = 16'h0033; mem[4] = 16'h0044; mem[5] = 16'h0055;
    mem[6] = 16'h8066; mem[7] = 16'h7777;
    mem[8'h40] = 16'h0123; mem[8'hFF] = 16'h0ABC;
    rst = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    step();
    rst = 1'b0;
    chk("rst_addr", Imem_Addr, 32'h0);
    chk("rst_valid", {31'h0, IF_ID_Valid}, 32'h0);
    chk("rst_dec", {16'h0, Dec_Instr}, 32'h0);
    chk("rst_cnt", {16'h0, Stall_Count}, 32'h0);
    chk("rst_ifpc", IF_ID_PC, 32'h0);

    step();
    chk("c1_instr", {16'h0, IF_ID_Instr}, 32'h1234);
    chk("c1_pc", IF_ID_PC, 32'h0);
    chk("c1_valid", {31'h0, IF_ID_Valid}, 32'h1);
    step();
    chk("c2_valid", {31'h0, IF_ID_Valid}, 32'h0);
    step();
    chk("c3_instr", {16'h0, IF_ID_Instr}, 32'h8001);
    chk("c3_imm", {16'h0, IF_ID_Imm}, 32'hBEEF);
    chk("c3_pc", IF_ID_PC, 32'h1);
    chk("c3_valid", {31'h0, IF_ID_Valid}, 32'h1);
    chk("c3_addr", Imem_Addr, 32'h3);
    step(); step();
    chk("pre_hold_addr", Imem_Addr, 32'h5);

    drive(1, 1, 1, 0, 32'h0);
    step();
    chk("hold1_addr", Imem_Addr, 32'h5);
    chk("hold1_instr", {16'h0, IF_ID_Instr}, 32'h0044);
    chk("hold1_dec", {16'h0, Dec_Instr}, 32'h0);
    chk("hold1_cnt", {16'h0, Stall_Count}, CNT_EN ? 32'd1 : 32'd0);
    step();
    chk("hold2_addr", Imem_Addr, 32'h5);
    chk("hold2_instr", {16'h0, IF_ID_Instr}, 32'h0044);
    chk("hold2_dec", {16'h0, Dec_Instr}, 32'h0);
    chk("hold2_cnt", {16'h0, Stall_Count}, CNT_EN ? 32'd2 : 32'd0);
    drive(0, 0, 0, 0, 32'h0);
    step();
    chk("resume_addr", Imem_Addr, 32'h6);
    chk("resume_instr", {16'h0, IF_ID_Instr}, 32'h0055);

    step();
    chk("imm_half_valid", {31'h0, IF_ID_Valid}, 32'h0);
    drive(1, 0, 0, 1, 32'h40);
    step();
    chk("br_addr", Imem_Addr, 32'h40);
    chk("br_valid", {31'h0, IF_ID_Valid}, 32'h0);
    chk("br_cnt", {16'h0, Stall_Count}, CNT_EN ? 32'd2 : 32'd0);
    drive(0, 0, 0, 0, 32'h0);
    step();
    chk("br_discard_instr", {16'h0, IF_ID_Instr}, 32'h0123);
    chk("br_discard_imm", {16'h0, IF_ID_Imm}, 32'h0);
    chk("br_discard_pc", IF_ID_PC, 32'h40);

    drive(0, 0, 0, 1, 32'hFFFF_FFFF);
    step();
    chk("wrap_pre", Imem_Addr, 32'hFFFF_FFFF);
    drive(0, 0, 0, 0, 32'h0);
    step();
    chk("wrap_addr", Imem_Addr, 32'h0);
    chk("wrap_instr", {16'h0, IF_ID_Instr}, 32'h0ABC);
    chk("wrap_pc", IF_ID_PC, 32'hFFFF_FFFF);

    drive(0, 1, 0, 0, 32'h0);
    step();
    chk("illegal_addr", Imem_Addr, 32'h0);
    chk("illegal_instr", {16'h0, IF_ID_Instr}, 32'h0ABC);
    chk("illegal_valid", {31'h0, IF_ID_Valid}, 32'h1);

    drive(1, 0, 0, 0, 32'h0);
    step();
    chk("bubble_instr", {16'h0, IF_ID_Instr}, 32'h0);
    chk("bubble_valid", {31'h0, IF_ID_Valid}, 32'h0);
    chk("bubble_addr", Imem_Addr, 32'h0);
    chk("bubble_cnt", {16'h0, Stall_Count}, CNT_EN ? 32'd3 : 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_addr", Imem_Addr, 32'h0);
    chk("midrst_valid", {31'h0, IF_ID_Valid}, 32'h0);
    chk("midrst_cnt", {16'h0, Stall_Count}, 32'h0);
    drive(0, 0, 0, 0, 32'h0);

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      Keep_PC = ($urandom_range(0, 3) == 0);
      Keep_Fetched_Instruction = ($urandom_range(0, 4) == 0);
      Flush_MUX_Selector = ($urandom_range(0, 3) == 0);
      Branch_Taken = ($urandom_range(0, 15) == 0);
      Branch_Target = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 255));
      step();
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 32'h0);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
